// File: rtl/param_reg_pkg.sv
// Shared defaults and parameter sanity helper for the param_reg pipeline.
// The optional change counter is enabled by PARAM_REG_CHG_CNT_EN.
package param_reg_pkg;

  localparam int DEF_W     = 8;
  localparam int DEF_DEPTH = 1;
  localparam int MAX_DEPTH = 16;
  localparam int CNT_W     = 16;

  function automatic bit params_ok(input int w, input int depth);
    return (w >= 1) && (depth >= 1) && (depth <= MAX_DEPTH);
  endfunction

endpackage

// File: rtl/param_reg_stage.sv
// Single W-bit pipeline flop with asynchronous active-high reset to RST_VAL.
// Macro PARAM_REG_CHG_CNT_EN has no effect on this file.
module param_reg_stage #(
  parameter int             W       = 8,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // resetn is asserted high despite its name
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) q <= RST_VAL;
    else        q <= d;
  end

endmodule

// File: rtl/param_reg.sv
// DEPTH-stage register pipeline with valid tracking and d_out parity.
// Define PARAM_REG_CHG_CNT_EN to add the saturating chg_cnt output.
module param_reg
  import param_reg_pkg::*;
#(
  parameter int           W       = DEF_W,
  parameter int           DEPTH   = DEF_DEPTH,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [W-1:0]     d_in,
  output logic [W-1:0]     d_out,
  output logic             vld,
  output logic             par
`ifdef PARAM_REG_CHG_CNT_EN
  ,
  output logic [CNT_W-1:0] chg_cnt
`endif
);

  if (!params_ok(W, DEPTH)) begin : g_bad_param
    $error("param_reg: illegal parameters W=%0d DEPTH=%0d", W, DEPTH);
  end

  logic [W-1:0]     stg_d [DEPTH];
  logic [W-1:0]     stg_q [DEPTH];
  logic [DEPTH-1:0] vld_sr;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign stg_d[k] = d_in;
    end else begin : g_chain
      assign stg_d[k] = stg_q[k-1];
    end

    param_reg_stage #(
      .W       (W),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk    (clk),
      .resetn (resetn),
      .d      (stg_d[k]),
      .q      (stg_q[k])
    );
  end

  // Ones shift in from reset release; the top bit marks real data at d_out
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) vld_sr <= '0;
    else        vld_sr <= (vld_sr << 1) | DEPTH'(1);
  end

  assign d_out = stg_q[DEPTH-1];
  assign vld   = vld_sr[DEPTH-1];
  assign par   = ^d_out;

`ifdef PARAM_REG_CHG_CNT_EN
  // A change is counted on the edge that loads a different value into d_out
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      chg_cnt <= '0;
    end else if ((stg_d[DEPTH-1] != stg_q[DEPTH-1]) && (chg_cnt != '1)) begin
      chg_cnt <= chg_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_param_reg.sv
// Directed scoreboard bench for param_reg across several parameter sets.
// Change-counter checks are compiled only with PARAM_REG_CHG_CNT_EN.
module tb_param_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic [7:0] d1_in = '0, d3_in = '0, rv_in = '0;
  logic       w1_in = 1'b0;
  logic [7:0] d1_out, d3_out, rv_out;
  logic       w1_out;
  logic       d1_vld, d3_vld, rv_vld, w1_vld;
  logic       d1_par, d3_par, rv_par, w1_par;
`ifdef PARAM_REG_CHG_CNT_EN
  logic [15:0] d1_cnt, d3_cnt, rv_cnt, w1_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int n_edge  = 0;

  logic [7:0] q1[$], q3[$], qr[$];
  logic       qw[$];
  logic [7:0] last1;
  int         exp_cnt;

  localparam logic [7:0] D3_RST = 8'h5A;
  localparam logic [7:0] RV_RST = 8'hA5;

  always #5 clk = ~clk;

  param_reg #(.W(8), .DEPTH(1), .RST_VAL(8'h00)) u_d1 (
    .clk(clk), .resetn(rst), .d_in(d1_in), .d_out(d1_out), .vld(d1_vld), .par(d1_par)
`ifdef PARAM_REG_CHG_CNT_EN
    , .chg_cnt(d1_cnt)
`endif
  );

  param_reg #(.W(8), .DEPTH(3), .RST_VAL(D3_RST)) u_d3 (
    .clk(clk), .resetn(rst), .d_in(d3_in), .d_out(d3_out), .vld(d3_vld), .par(d3_par)
`ifdef PARAM_REG_CHG_CNT_EN
    , .chg_cnt(d3_cnt)
`endif
  );

  param_reg #(.W(8), .DEPTH(1), .RST_VAL(RV_RST)) u_rv (
    .clk(clk), .resetn(rst), .d_in(rv_in), .d_out(rv_out), .vld(rv_vld), .par(rv_par)
`ifdef PARAM_REG_CHG_CNT_EN
    , .chg_cnt(rv_cnt)
`endif
  );

  param_reg #(.W(1), .DEPTH(1), .RST_VAL(1'b0)) u_w1 (
    .clk(clk), .resetn(rst), .d_in(w1_in), .d_out(w1_out), .vld(w1_vld), .par(w1_par)
`ifdef PARAM_REG_CHG_CNT_EN
    , .chg_cnt(w1_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_d1_out"}, 16'(d1_out), 16'h00);
    chk({tag, "_d1_vld"}, 16'(d1_vld), 16'h0);
    chk({tag, "_d1_par"}, 16'(d1_par), 16'h0);
    chk({tag, "_d3_out"}, 16'(d3_out), 16'(D3_RST));
    chk({tag, "_d3_vld"}, 16'(d3_vld), 16'h0);
    chk({tag, "_rv_out"}, 16'(rv_out), 16'(RV_RST));
    chk({tag, "_rv_vld"}, 16'(rv_vld), 16'h0);
    chk({tag, "_rv_par"}, 16'(rv_par), 16'h0);
    chk({tag, "_w1_out"}, 16'(w1_out), 16'h0);
    chk({tag, "_w1_vld"}, 16'(w1_vld), 16'h0);
`ifdef PARAM_REG_CHG_CNT_EN
    chk({tag, "_d1_cnt"}, d1_cnt, 16'h0);
`endif
  endtask

  task automatic release_rst;
    rst    = 1'b0;
    n_edge = 0;
    q1.delete(); q3.delete(); qr.delete(); qw.delete();
    repeat (2) q3.push_back(D3_RST);
    last1   = 8'h00;
    exp_cnt = 0;
  endtask

  task automatic step(input logic [7:0] a1, input logic [7:0] a3,
                      input logic [7:0] ar, input logic aw);
    logic [7:0] e1, e3, er;
    logic       ew;
    d1_in = a1; d3_in = a3; rv_in = ar; w1_in = aw;
    q1.push_back(a1); q3.push_back(a3); qr.push_back(ar); qw.push_back(aw);
    tick();
    n_edge++;
    e1 = q1.pop_front(); e3 = q3.pop_front(); er = qr.pop_front(); ew = qw.pop_front();
    chk("d1_out", 16'(d1_out), 16'(e1));
    chk("d1_par", 16'(d1_par), 16'(^e1));
    chk("d1_vld", 16'(d1_vld), 16'(n_edge >= 1));
    chk("d3_out", 16'(d3_out), 16'(e3));
    chk("d3_par", 16'(d3_par), 16'(^e3));
    chk("d3_vld", 16'(d3_vld), 16'(n_edge >= 3));
    chk("rv_out", 16'(rv_out), 16'(er));
    chk("rv_vld", 16'(rv_vld), 16'(n_edge >= 1));
    chk("w1_out", 16'(w1_out), 16'(ew));
    chk("w1_par", 16'(w1_par), 16'(ew));
    chk("w1_vld", 16'(w1_vld), 16'(n_edge >= 1));
`ifdef PARAM_REG_CHG_CNT_EN
    if (e1 != last1) exp_cnt++;
    last1 = e1;
    chk("d1_cnt", d1_cnt, 16'(exp_cnt));
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    repeat (7) begin
      tick();
      check_reset_state("rst_hold");
    end
    d1_in = 8'hFF; d3_in = 8'hFF; rv_in = 8'hFF; w1_in = 1'b1;
    tick();
    check_reset_state("rst_din_ff");

    release_rst();
    step(8'h24, 8'h11, 8'h3C, 1'b0);
    step(8'h81, 8'h22, 8'h00, 1'b1);
    step(8'h09, 8'h33, 8'hFF, 1'b0);
    step(8'h63, 8'h44, 8'h5A, 1'b1);
    step(8'h01, 8'h55, 8'h01, 1'b1);
    step(8'h07, 8'h66, 8'h42, 1'b0);
    step(8'hFE, 8'h77, 8'h99, 1'b0);
    step(8'h80, 8'h88, 8'h63, 1'b1);

    // Asynchronous reset between edges, with in-flight data in every pipeline
    chk("pre_rst_rv_out", 16'(rv_out), 16'h63);
    #2;
    rst = 1'b1;
    #1;
    check_reset_state("async_rst");
    tick();
    check_reset_state("async_rst_edge");

    release_rst();
    step(8'h01, 8'h99, 8'hAA, 1'b0);
    step(8'h01, 8'hAB, 8'h55, 1'b0);
    step(8'h02, 8'hCD, 8'h0F, 1'b1);
    step(8'h03, 8'hEF, 8'hF0, 1'b0);
`ifdef PARAM_REG_CHG_CNT_EN
    chk("chg_cnt_final", d1_cnt, 16'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
